// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for the UART TX arbiter. slave = arbiter side,
// master = requesters plus transmitter (or the bench standing in for them).
interface uart_tx_arbiter_if #(
  parameter int NumReq = 2
);
  logic [NumReq-1:0][7:0] ReqData;
  logic [NumReq-1:0]      ReqValid;
  logic [NumReq-1:0]      ReqLast;
  logic [NumReq-1:0]      ReqReady;
  logic [NumReq-1:0]      Grant;
  logic [7:0]             TxData;
  logic                   TxValid;
  logic                   TxReady;
  logic                   Busy;

  modport slave (
    input  ReqData, ReqValid, ReqLast, TxReady,
    output ReqReady, TxData, TxValid, Grant, Busy
  );

  modport master (
    output ReqData, ReqValid, ReqLast, TxReady,
    input  ReqReady, TxData, TxValid, Grant, Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NumReq byte streams;
// a grant is held for a whole message (Last, burst cap or idle timeout).
module uart_tx_arbiter #(
  parameter int NumReq      = 2,
  parameter int MaxBurst    = 16,
  parameter int IdleTimeout = 4096
) (
  input  logic                Clock,
  input  logic                Reset,
  uart_tx_arbiter_if.slave    bus
);
  localparam int BW = $clog2(MaxBurst + 1);
  localparam int IW = $clog2(IdleTimeout + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [1:0]        g_q, g_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [BW-1:0]     byte_q, byte_d;
  logic [IW-1:0]     idle_q, idle_d;

  logic              sel_vld, sel_last, xfer, rel, found;
  logic [7:0]        sel_data;
  logic [1:0]        pick;

  // Datapath is steered by the one-hot registered grant, so every control
  // output is a single AND level off flops and inputs; all-zero in IDLE.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NumReq; i++)
      sel_data = sel_data | (bus.ReqData[i] & {8{grant_q[i]}});
  end

  assign sel_vld  = |(grant_q & bus.ReqValid);
  assign sel_last = |(grant_q & bus.ReqLast);
  assign xfer     = sel_vld & bus.TxReady;

  assign bus.TxData   = sel_data;
  assign bus.TxValid  = sel_vld;
  assign bus.ReqReady = grant_q & {NumReq{bus.TxReady}};
  assign bus.Grant    = grant_q;
  assign bus.Busy     = |grant_q;

  // First valid requester starting at ptr_q; scanning k downward lets the
  // closest candidate overwrite any later one.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--)
      for (int i = 0; i < NumReq; i++)
        if (bus.ReqValid[i] && (i == (int'(ptr_q) + k) % NumReq)) begin
          pick  = 2'(i);
          found = 1'b1;
        end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    idle_d  = idle_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCK;
          g_d     = pick;
          byte_d  = '0;
          idle_d  = '0;
          for (int i = 0; i < NumReq; i++)
            grant_d[i] = (pick == 2'(i));
        end
      end
      LOCK: begin
        if (sel_vld)
          idle_d = '0;
        else if (idle_q != IW'(IdleTimeout))
          idle_d = idle_q + 1'b1;
        if (xfer)
          byte_d = byte_q + 1'b1;
        // Last and burst cap on the same transfer collapse into one release.
        rel = (!sel_vld && idle_q == IW'(IdleTimeout - 1)) ||
              (xfer && (sel_last || byte_q == BW'(MaxBurst - 1)));
        if (rel) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = 2'((int'(g_q) + 1) % NumReq);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      byte_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      idle_q  <= idle_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized plus directed bench for uart_tx_arbiter against a message-level
// reference model (owner / pointer / byte and idle tallies).
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int MB = 4;
  localparam int IT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NumReq(N)) bus();

  uart_tx_arbiter #(.NumReq(N), .MaxBurst(MB), .IdleTimeout(IT)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // model: current owner (-1 = none), round-robin pointer, tallies
  int owner, ptr, nbytes, nidle, xfers;
  logic [N-1:0] acc;

  logic [N-1:0]      gv, gl;
  logic [N-1:0][7:0] gd, d;
  int                seq [N];
  int                rate;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner  = -1;
    ptr    = 0;
    nbytes = 0;
    nidle  = 0;
  endtask

  // Apply inputs, check outputs against the model, advance the model by one edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic [N-1:0][7:0] dd, input logic r);
    logic [31:0] eg, er;
    logic [7:0]  ed;
    logic        ev;
    bit          rl;
    int          nw;
    bus.ReqValid = v;
    bus.ReqLast  = l;
    bus.ReqData  = dd;
    bus.TxReady  = r;
    #3;
    eg = (owner < 0) ? 32'd0 : (32'd1 << owner);
    ev = (owner >= 0) && v[owner];
    ed = (owner >= 0) ? dd[owner] : 8'h00;
    er = r ? eg : 32'd0;
    chk("grant",   bus.Grant,    eg);
    chk("txvalid", bus.TxValid,  ev);
    chk("txdata",  bus.TxData,   ed);
    chk("ready",   bus.ReqReady, er);
    chk("busy",    bus.Busy,     owner >= 0);
    acc = '0;
    if (owner < 0) begin
      nw = -1;
      for (int k = 0; k < N; k++)
        if (nw < 0 && v[(ptr + k) % N]) nw = (ptr + k) % N;
      if (nw >= 0) begin
        owner  = nw;
        nbytes = 0;
        nidle  = 0;
      end
    end else begin
      rl = 0;
      if (v[owner]) nidle = 0;
      else begin
        nidle++;
        if (nidle >= IT) rl = 1;
      end
      if (v[owner] && r) begin
        acc[owner] = 1'b1;
        xfers++;
        nbytes++;
        if (l[owner] || nbytes == MB) rl = 1;
      end
      if (rl) begin
        ptr   = (owner + 1) % N;
        owner = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    xfers = 0;
    rst = 1'b1;
    bus.ReqValid = '0;
    bus.ReqLast  = '0;
    bus.ReqData  = '0;
    bus.TxReady  = 1'b0;
    #12;
    chk("rst_grant",   bus.Grant,    0);
    chk("rst_txvalid", bus.TxValid,  0);
    chk("rst_ready",   bus.ReqReady, 0);
    chk("rst_busy",    bus.Busy,     0);
    chk("rst_txdata",  bus.TxData,   0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // req0 message 41 42 43(last); then both valid -> pointer favours req1
    d = '0;
    d[0] = 8'h41;
    step(3'b001, 3'b000, d, 1'b1);
    step(3'b001, 3'b000, d, 1'b1);
    d[0] = 8'h42;
    step(3'b001, 3'b000, d, 1'b1);
    d[0] = 8'h43;
    step(3'b001, 3'b001, d, 1'b1);
    step(3'b000, 3'b000, d, 1'b1);
    d[1] = 8'h60;
    step(3'b011, 3'b000, d, 1'b1);
    step(3'b010, 3'b010, d, 1'b1);
    step(3'b000, 3'b000, d, 1'b1);

    // idle timeout with req1 pending
    d[0] = 8'h50;
    step(3'b001, 3'b000, d, 1'b1);
    step(3'b001, 3'b000, d, 1'b1);
    repeat (IT) step(3'b010, 3'b000, d, 1'b1);
    step(3'b010, 3'b000, d, 1'b1);
    step(3'b010, 3'b010, d, 1'b1);
    step(3'b000, 3'b000, d, 1'b1);

    // transmitter stalled 50 cycles; req1 Last/Valid must be ignored
    step(3'b001, 3'b000, d, 1'b1);
    repeat (50) step(3'b011, 3'b010, d, 1'b0);
    step(3'b001, 3'b001, d, 1'b1);
    step(3'b000, 3'b000, d, 1'b1);

    // randomized traffic: dense, then sparse so timeouts occur
    gv = '0;
    gl = '0;
    gd = '0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      rate = (c < 1500) ? 70 : 12;
      for (int i = 0; i < N; i++) begin
        if (!gv[i] && $urandom_range(0, 99) < rate) begin
          gv[i] = 1'b1;
          gl[i] = ($urandom_range(0, 5) == 0);
          gd[i] = {i[1:0], seq[i][5:0]};
        end else if (gv[i] && $urandom_range(0, 99) < 3) begin
          gv[i] = 1'b0;
        end
      end
      step(gv, gl, gd, $urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          gv[i] = 1'b0;
          seq[i]++;
        end
    end
    repeat (IT + 2) step(3'b000, 3'b000, gd, 1'b1);

    // async reset mid-message (req1 locked, two bytes sent)
    d[1] = 8'h70;
    step(3'b010, 3'b000, d, 1'b1);
    step(3'b010, 3'b000, d, 1'b1);
    step(3'b010, 3'b000, d, 1'b1);
    bus.ReqValid = 3'b011;
    bus.TxReady  = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_grant",   bus.Grant,    0);
    chk("arst_txvalid", bus.TxValid,  0);
    chk("arst_ready",   bus.ReqReady, 0);
    chk("arst_busy",    bus.Busy,     0);
    chk("arst_txdata",  bus.TxData,   0);
    model_reset();
    bus.ReqValid = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step(3'b011, 3'b000, d, 1'b1);
    step(3'b011, 3'b001, d, 1'b1);
    step(3'b000, 3'b000, d, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
